// File: rtl/mod_square_pow_seq_if.sv
// Handshake bundle for the GF(2^257) repeated-squaring sequencer.
// The master side issues (a, k) and consumes a^(2^k); the slave side is the sequencer.
interface mod_square_pow_seq_if #(
  parameter int W     = 257,
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [CNT_W-1:0] in_k;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_k, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_k, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mod_square_pow_seq.sv
// Repeated squaring in GF(2^257) mod x^257 + x^12 + 1: computes a^(2^k) one squaring per clock.
// gf257_sqr is the combinational squarer; mod_square_pow_seq sequences it from a single accumulator.
module gf257_sqr (
  input  logic [256:0] a,
  output logic [256:0] y
);
  logic [512:0] spread;
  logic [255:0] hi;
  logic [267:0] fold1;
  logic [10:0]  wrap;

  // Squaring in characteristic 2 just interleaves zeros between the coefficients.
  for (genvar i = 0; i < 257; i++) begin : g_even
    assign spread[2*i] = a[i];
  end
  for (genvar i = 0; i < 256; i++) begin : g_odd
    assign spread[2*i+1] = 1'b0;
  end

  // x^257 = x^12 + 1: fold the high half once, then fold the 11 bits that spill past x^256 again.
  assign hi    = spread[512:257];
  assign fold1 = {12'b0, hi} ^ {hi, 12'b0};
  assign wrap  = fold1[267:257];
  assign y     = spread[256:0] ^ fold1[256:0] ^ {246'b0, wrap} ^ {234'b0, wrap, 12'b0};
endmodule

module mod_square_pow_seq #(
  parameter int W     = 257,
  parameter int CNT_W = 9
) (
  input logic                clk,
  input logic                rst,
  mod_square_pow_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_sq;
  logic [CNT_W-1:0] remaining;

  gf257_sqr u_sqr (
    .a (acc),
    .y (acc_sq)
  );

  // remaining only moves in RUN, and RUN is left exactly when it reaches 1, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc       <= bus.in_data;
            remaining <= bus.in_k;
            state     <= (bus.in_k == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc       <= acc_sq;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = acc;
endmodule

// File: tb/tb_mod_square_pow_seq.sv
// Self-checking bench for mod_square_pow_seq: directed vector table, corner-case sequences,
// and random operations scored against a polynomial-arithmetic reference model.
module tb_mod_square_pow_seq;
  localparam int W     = 257;
  localparam int CNT_W = 9;

  typedef logic [W-1:0] elem_t;
  typedef struct {
    elem_t            a;
    logic [CNT_W-1:0] k;
    elem_t            expected;
    int               latency;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    checks = 0;
  int    errors = 0;
  elem_t expq[$];

  mod_square_pow_seq_if #(.W(W), .CNT_W(CNT_W)) bus ();

  mod_square_pow_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: generic shift-and-add field multiply, reducing with x^257 = x^12 + 1.
  function automatic elem_t gf_mul(input elem_t a, input elem_t b);
    elem_t r;
    logic  carry;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      carry = r[W-1];
      r = r << 1;
      if (carry) r = r ^ elem_t'(257'h1001);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic elem_t ref_pow(input elem_t a, input logic [CNT_W-1:0] k);
    elem_t r;
    r = a;
    for (int i = 0; i < int'(k); i++) r = gf_mul(r, r);
    return r;
  endfunction

  function automatic elem_t rand_elem();
    logic [287:0] tmp;
    for (int i = 0; i < 9; i++) tmp[i*32 +: 32] = $urandom();
    return tmp[W-1:0];
  endfunction

  function automatic elem_t bit_at(input int n);
    elem_t e;
    e = '0;
    e[n] = 1'b1;
    return e;
  endfunction

  task automatic check_output(input string name, input elem_t actual, input elem_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted operation must come back once, in order, with the model's value.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) check_output("sb_unexpected_result", elem_t'(1'b1), elem_t'(1'b0));
        else check_output("sb_result", bus.out_data, expq.pop_front());
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(ref_pow(bus.in_data, bus.in_k));
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input elem_t a, input logic [CNT_W-1:0] k, input int hold,
                                input string tag, output elem_t res, output int lat);
    bit    ready_seen;
    bit    accepted;
    int    leaks;
    res = '0;
    lat = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    bus.in_k      = k;
    bus.out_ready = (hold == 0);
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      ready_seen = bus.in_ready;
      tick();
      accepted = ready_seen;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = rand_elem();
    bus.in_k     = CNT_W'($urandom());
    if (!accepted) begin
      check_output({tag, "_accept_timeout"}, elem_t'(accepted), elem_t'(1'b1));
      return;
    end
    lat   = 1;
    leaks = 0;
    while (!bus.out_valid && lat < 600) begin
      if (bus.in_ready || !bus.busy) leaks++;
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      check_output({tag, "_result_timeout"}, elem_t'(bus.out_valid), elem_t'(1'b1));
      return;
    end
    check_output({tag, "_ready_low_while_running"}, elem_t'(leaks), elem_t'(0));
    res = bus.out_data;
    if (hold > 0) begin
      leaks = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!bus.out_valid || bus.in_ready || bus.out_data !== res) leaks++;
      end
      check_output({tag, "_stable_under_backpressure"}, elem_t'(leaks), elem_t'(0));
      bus.out_ready = 1'b1;
    end
    tick();
    check_output({tag, "_idle_after_handoff"},
                 elem_t'({bus.out_valid, bus.in_ready, bus.busy}), elem_t'(3'b010));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t             vecs[7];
    elem_t            res;
    elem_t            a;
    elem_t            e;
    int               lat;
    int               gap;
    bit               ready_seen;
    bit               accepted;
    logic [CNT_W-1:0] k;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_k      = '0;
    bus.out_ready = 1'b0;

    #1 rst = 1'b1;
    #1;
    check_output("reset_outputs", elem_t'({bus.in_ready, bus.out_valid, bus.busy}), elem_t'(3'b100));
    check_output("reset_out_data", bus.out_data, elem_t'(0));
    tick();
    tick();
    rst = 1'b0;

    e = bit_at(255) | bit_at(22) | bit_at(10);
    vecs[0] = '{a: bit_at(1),   k: 9'd1,   expected: bit_at(2),               latency: 2};
    vecs[1] = '{a: bit_at(1),   k: 9'd8,   expected: bit_at(256),             latency: 9};
    vecs[2] = '{a: bit_at(1),   k: 9'd9,   expected: e,                       latency: 10};
    vecs[3] = '{a: bit_at(129), k: 9'd1,   expected: bit_at(1) | bit_at(13),  latency: 2};
    vecs[4] = '{a: bit_at(3),   k: 9'd2,   expected: bit_at(12),              latency: 3};
    vecs[5] = '{a: bit_at(0),   k: 9'd511, expected: bit_at(0),               latency: 512};
    vecs[6] = '{a: '0,          k: 9'd5,   expected: '0,                      latency: 6};
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].k, 0, $sformatf("vec%0d", i), res, lat);
      check_output($sformatf("vec%0d_data", i), res, vecs[i].expected);
      check_output($sformatf("vec%0d_latency", i), elem_t'(lat), elem_t'(vecs[i].latency));
    end

    // k = 0 passes the operand straight through, then sits in DONE under backpressure.
    a = rand_elem();
    a[256:244] = 13'h1ABC;
    apply_stimulus(a, 9'd0, 5, "k0_hold", res, lat);
    check_output("k0_data", res, a);
    check_output("k0_latency", elem_t'(lat), elem_t'(1));

    // Reset seven cycles into a k = 20 run must drop everything without a result.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = rand_elem();
    bus.in_k      = 9'd20;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      ready_seen = bus.in_ready;
      tick();
      accepted = ready_seen;
    end
    bus.in_valid = 1'b0;
    check_output("midrun_accept", elem_t'(accepted), elem_t'(1'b1));
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check_output("midrun_reset_outputs", elem_t'({bus.in_ready, bus.out_valid, bus.busy}), elem_t'(3'b100));
    check_output("midrun_reset_out_data", bus.out_data, elem_t'(0));
    tick();
    tick();
    check_output("midrun_no_valid", elem_t'(bus.out_valid), elem_t'(1'b0));
    rst = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(bit_at(3), 9'd2, 0, "post_reset", res, lat);
    check_output("post_reset_data", res, bit_at(12));

    // Back-to-back with in_valid held: second accept lands k1 + 2 edges after the first.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = rand_elem();
    bus.in_k      = 9'd3;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      ready_seen = bus.in_ready;
      tick();
      accepted = ready_seen;
    end
    bus.in_data = rand_elem();
    bus.in_k    = 9'd2;
    gap = 0;
    accepted = 1'b0;
    while (!accepted && gap < 50) begin
      ready_seen = bus.in_ready;
      tick();
      gap++;
      accepted = ready_seen;
    end
    bus.in_valid = 1'b0;
    check_output("b2b_accept_gap", elem_t'(gap), elem_t'(5));
    gap = 0;
    while (!bus.out_valid && gap < 50) begin
      tick();
      gap++;
    end
    check_output("b2b_second_valid", elem_t'(bus.out_valid), elem_t'(1'b1));
    tick();
    bus.out_ready = 1'b0;

    // Random operands and counts, occasionally with consumer backpressure.
    for (int i = 0; i < 200; i++) begin
      a = rand_elem();
      k = (i % 25 == 0) ? CNT_W'($urandom_range(100, 300)) : CNT_W'($urandom_range(0, 40));
      apply_stimulus(a, k, (i % 7 == 0) ? int'($urandom_range(1, 3)) : 0,
                     $sformatf("rnd%0d", i), res, lat);
      check_output($sformatf("rnd%0d_latency", i), elem_t'(lat), elem_t'(int'(k) + 1));
    end

    tick();
    check_output("sb_drained", elem_t'(expq.size()), elem_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
